// File: rtl/sdpb_fifo_pkg.sv
// sdpb_fifo_pkg: shared widths and pointer type for the SDPB FIFO controller.
package sdpb_fifo_pkg;
    localparam int SDPB_ADDR_W = 3;
    localparam int SDPB_DATA_W = 32;
    localparam int SDPB_BE_W   = 4;
    typedef logic [SDPB_ADDR_W:0] ptr_t;
endpackage

// File: rtl/sdpb_fifo_skid.sv
// sdpb_fifo_skid: 2-entry output skid buffer; head is the registered output word.
module sdpb_fifo_skid
    import sdpb_fifo_pkg::*;
#(
    parameter int DATA_W = SDPB_DATA_W
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              flush,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [1:0]        cnt,
    output logic [DATA_W-1:0] head
);
    logic [DATA_W-1:0] tail;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt  <= '0;
            head <= '0;
            tail <= '0;
        end else if (flush) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + {1'b0, push} - {1'b0, pop};
            if (pop && cnt == 2'd2)
                head <= tail;
            else if (push && (cnt == 2'd0 || (pop && cnt == 2'd1)))
                head <= din;
            if (push && ((cnt == 2'd1 && !pop) || (cnt == 2'd2 && pop)))
                tail <= din;
        end
    end
endmodule

// File: rtl/sdpb_fifo_ctrl.sv
// sdpb_fifo_ctrl: FIFO controller driving a Gowin_SDPB with FWFT output via a 2-entry skid.
// Optional SDPB_FIFO_LEVEL_EN adds level and almost_full outputs.
module sdpb_fifo_ctrl
    import sdpb_fifo_pkg::*;
#(
    parameter int ADDR_W = SDPB_ADDR_W,
    parameter int DATA_W = SDPB_DATA_W
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_W-1:0]   in_data,
    input  logic [DATA_W/8-1:0] in_strb,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_W-1:0]   out_data,
    output logic                ram_cea,
    output logic [ADDR_W-1:0]   ram_ada,
    output logic [DATA_W-1:0]   ram_din,
    output logic [DATA_W/8-1:0] ram_byte_ena,
    output logic                ram_ceb,
    output logic [ADDR_W-1:0]   ram_adb,
    output logic                ram_oce,
    output logic                ram_reset,
    input  logic [DATA_W-1:0]   ram_dout
`ifdef SDPB_FIFO_LEVEL_EN
    ,
    output logic [ADDR_W+1:0]   level,
    output logic                almost_full
`endif
);
    logic [ADDR_W:0] wr_ptr, rd_ptr;
    logic            rd_inflight, ready_en, empty, full, wr, pop, issue;
    logic [1:0]      skid_cnt;

    assign empty     = wr_ptr == rd_ptr;
    assign full      = (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]) && (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]);
    assign in_ready  = ready_en && !full && !flush;
    assign wr        = in_valid && in_ready;
    assign out_valid = skid_cnt != 2'd0;
    assign pop       = out_valid && out_ready && !flush;
    // Only issue a read when the skid is guaranteed room for its data next cycle.
    assign issue     = !empty && !flush &&
                       ({1'b0, skid_cnt} + {2'b0, rd_inflight} + 3'd1 <= 3'd2 - {2'b0, pop});

    assign ram_cea      = wr;
    assign ram_ada      = wr_ptr[ADDR_W-1:0];
    assign ram_din      = in_data;
    assign ram_byte_ena = in_strb;
    assign ram_ceb      = issue;
    assign ram_adb      = rd_ptr[ADDR_W-1:0];
    assign ram_oce      = 1'b1;
    assign ram_reset    = !resetn;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            rd_inflight <= 1'b0;
            ready_en    <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            if (flush) begin
                wr_ptr      <= '0;
                rd_ptr      <= '0;
                rd_inflight <= 1'b0;
            end else begin
                wr_ptr      <= wr_ptr + {{ADDR_W{1'b0}}, wr};
                rd_ptr      <= rd_ptr + {{ADDR_W{1'b0}}, issue};
                rd_inflight <= issue;
            end
        end
    end

    sdpb_fifo_skid #(.DATA_W(DATA_W)) u_skid (
        .clk   (clk),
        .resetn(resetn),
        .flush (flush),
        .push  (rd_inflight),
        .pop   (pop),
        .din   (ram_dout),
        .cnt   (skid_cnt),
        .head  (out_data)
    );

`ifdef SDPB_FIFO_LEVEL_EN
    logic [ADDR_W+1:0] occ;
    logic [ADDR_W:0]   ram_occ;
    assign ram_occ = wr_ptr - rd_ptr;
    assign occ     = {1'b0, ram_occ} + {{(ADDR_W+1){1'b0}}, rd_inflight} + {{ADDR_W{1'b0}}, skid_cnt};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            level       <= '0;
            almost_full <= 1'b0;
        end else begin
            level       <= occ;
            almost_full <= occ >= (ADDR_W+2)'(2**ADDR_W);
        end
    end
`endif
endmodule

// File: tb/tb_sdpb_fifo_ctrl.sv
// tb_sdpb_fifo_ctrl: table-driven and directed checks of sdpb_fifo_ctrl against a behavioural SDPB.
module tb_sdpb_fifo_ctrl;
    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic [3:0]  in_strb = 4'hF;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic        ram_cea, ram_ceb, ram_oce, ram_reset;
    logic [2:0]  ram_ada, ram_adb;
    logic [31:0] ram_din, ram_dout;
    logic [3:0]  ram_byte_ena;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    sdpb_fifo_ctrl dut (
        .clk(clk), .resetn(resetn), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_strb(in_strb),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .ram_cea(ram_cea), .ram_ada(ram_ada), .ram_din(ram_din), .ram_byte_ena(ram_byte_ena),
        .ram_ceb(ram_ceb), .ram_adb(ram_adb), .ram_oce(ram_oce), .ram_reset(ram_reset),
        .ram_dout(ram_dout)
    );

    // Behavioural SDPB: byte-enabled write on port A, registered read on port B.
    logic [31:0] mem [8];
    initial begin
        for (int i = 0; i < 8; i++) mem[i] = '0;
        ram_dout = '0;
    end
    always @(posedge clk) begin
        if (ram_cea)
            for (int b = 0; b < 4; b++)
                if (ram_byte_ena[b]) mem[ram_ada][8*b +: 8] <= ram_din[8*b +: 8];
        if (ram_ceb) ram_dout <= mem[ram_adb];
    end

    typedef struct {
        logic        iv;
        logic [31:0] d;
        logic [3:0]  s;
        logic        ordy;
        logic        e_ir;
        logic        e_ov;
        logic [31:0] e_od;
        logic        e_cea;
        logic        e_ceb;
    } vec_t;
    vec_t tbl[17];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        flush = 1'b0;
        next_cycle();
        next_cycle();
        resetn = 1'b1;
        next_cycle();
    endtask

    task automatic send(input logic [31:0] d, input logic [3:0] s);
        bit ok = 0;
        in_valid = 1'b1;
        in_data = d;
        in_strb = s;
        for (int k = 0; k < 50 && !ok; k++) begin
            @(negedge clk);
            ok = in_ready;
            next_cycle();
        end
        in_valid = 1'b0;
        if (!ok) chk("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic recv(input logic [31:0] exp, input string nm);
        bit got = 0;
        out_ready = 1'b1;
        for (int k = 0; k < 50 && !got; k++) begin
            @(negedge clk);
            if (out_valid) begin
                chk(nm, out_data, exp);
                got = 1;
            end
            next_cycle();
        end
        out_ready = 1'b0;
        if (!got) chk({nm, "_timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int pops, t0, t1, sent, got;
        bit stale;

        tbl[0] = '{1'b1, 32'hDEADBEEF, 4'hF, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0};
        tbl[1] = '{1'b0, 32'h0, 4'hF, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1};
        tbl[2] = '{1'b0, 32'h0, 4'hF, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0};
        tbl[3] = '{1'b0, 32'h0, 4'hF, 1'b1, 1'b1, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0};
        tbl[4] = '{1'b0, 32'h0, 4'hF, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0};
        for (int i = 0; i < 12; i++)
            tbl[5+i] = '{1'b1, 32'h100 + i, 4'hF, 1'b0, i < 10, i >= 3, 32'h100, i < 10, i == 1 || i == 2};

        // Reset with a pending write beat
        in_valid = 1'b1;
        in_data = 32'h12345678;
        next_cycle();
        next_cycle();
        @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_cea", {31'd0, ram_cea}, 32'd0);
        chk("rst_ceb", {31'd0, ram_ceb}, 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_ram_reset", {31'd0, ram_reset}, 32'd1);
        next_cycle();
        resetn = 1'b1;
        in_valid = 1'b0;
        next_cycle();
        @(negedge clk);
        chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("post_rst_oce", {31'd0, ram_oce}, 32'd1);
        next_cycle();

        // Single word latency, then fill to 10 words
        for (int i = 0; i < 17; i++) begin
            in_valid = tbl[i].iv;
            in_data = tbl[i].d;
            in_strb = tbl[i].s;
            out_ready = tbl[i].ordy;
            @(negedge clk);
            chk($sformatf("v%0d_in_ready", i), {31'd0, in_ready}, {31'd0, tbl[i].e_ir});
            chk($sformatf("v%0d_out_valid", i), {31'd0, out_valid}, {31'd0, tbl[i].e_ov});
            chk($sformatf("v%0d_cea", i), {31'd0, ram_cea}, {31'd0, tbl[i].e_cea});
            chk($sformatf("v%0d_ceb", i), {31'd0, ram_ceb}, {31'd0, tbl[i].e_ceb});
            if (tbl[i].e_ov) chk($sformatf("v%0d_out_data", i), out_data, tbl[i].e_od);
            next_cycle();
        end

        // Drain the 10 stored words in order
        in_valid = 1'b0;
        out_ready = 1'b1;
        pops = 0;
        t0 = -1;
        t1 = -1;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            if (out_valid) begin
                chk("drain_data", out_data, 32'h100 + pops);
                if (pops == 0) t0 = c;
                if (pops == 1) t1 = c;
                pops++;
            end
            next_cycle();
        end
        out_ready = 1'b0;
        chk("drain_count", pops, 32'd10);
        chk("drain_back_to_back", t1 - t0, 32'd1);

        // Stream 40 words with random consumer stalls
        do_reset();
        sent = 0;
        got = 0;
        for (int c = 0; c < 3000 && got < 40; c++) begin
            in_valid = sent < 40;
            in_data = 32'hA000_0000 + sent;
            in_strb = 4'hF;
            out_ready = $urandom_range(0, 3) != 0;
            @(negedge clk);
            if (in_valid && in_ready) sent++;
            if (out_valid && out_ready) begin
                chk("wrap_data", out_data, 32'hA000_0000 + got);
                got++;
            end
            next_cycle();
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        chk("wrap_count", got, 32'd40);

        // Partial strobe merges with the stale slot content
        do_reset();
        send(32'h11223344, 4'hF);
        recv(32'h11223344, "strobe_first");
        for (int i = 0; i < 7; i++) begin
            send(32'h700 + i, 4'hF);
            recv(32'h700 + i, "strobe_filler");
        end
        send(32'hAABBCCDD, 4'b0011);
        recv(32'h1122CCDD, "strobe_merge");

        // Flush with a read in flight
        do_reset();
        for (int i = 0; i < 5; i++) send(32'h50 + i, 4'hF);
        next_cycle();
        next_cycle();
        next_cycle();
        recv(32'h50, "flush_pre_pop");
        @(negedge clk);
        chk("flush_issue_before", {31'd0, ram_ceb}, 32'd1);
        next_cycle();
        flush = 1'b1;
        in_valid = 1'b1;
        in_data = 32'hBAD0BAD0;
        @(negedge clk);
        chk("flush_in_ready", {31'd0, in_ready}, 32'd0);
        chk("flush_cea", {31'd0, ram_cea}, 32'd0);
        next_cycle();
        flush = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
        next_cycle();
        send(32'h5, 4'hF);
        recv(32'h5, "flush_new_word");
        stale = 0;
        out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (out_valid) stale = 1;
            next_cycle();
        end
        out_ready = 1'b0;
        chk("flush_no_stale", {31'd0, stale}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
